// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states and
// datapath select values. The execute stage and the regfile use the same constants.
package multicycle_control_fsm_pkg;

    // Opcodes held in instr[15:12]
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0011;
    localparam logic [3:0] OP_SW   = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b0101;
    localparam logic [3:0] OP_BGT  = 4'b0110;
    localparam logic [3:0] OP_JAL  = 4'b0111;

    // ALU input A select
    localparam logic       ALUIN1_PC   = 1'b0;
    localparam logic       ALUIN1_A    = 1'b1;

    // ALU input B select
    localparam logic [1:0] ALUIN2_B    = 2'b00;
    localparam logic [1:0] ALUIN2_TWO  = 2'b01;
    localparam logic [1:0] ALUIN2_IMM  = 2'b10;
    localparam logic [1:0] ALUIN2_ZERO = 2'b11;

    // ALU operation
    localparam logic       ALUOP_ADD   = 1'b0;
    localparam logic       ALUOP_SUB   = 1'b1;

    // Register write-back source
    localparam logic [1:0] WB_ALU      = 2'b00;
    localparam logic [1:0] WB_MEM      = 2'b01;
    localparam logic [1:0] WB_PC       = 2'b10;

    // Memory address source
    localparam logic       IORD_PC     = 1'b0;
    localparam logic       IORD_ALU    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_BRANCH = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    // Legal opcodes occupy 0000-0111; anything with instr[15] set is illegal
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the multicycle controller (master) and the
// datapath/memory side (slave).
interface multicycle_control_fsm_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [15:0]      instr;
    logic             zero;
    logic             pos;
    logic             mem_ready;
    logic             aluin1;
    logic [1:0]       aluin2;
    logic             aluop;
    logic             pc_write;
    logic             ir_write;
    logic             reg_write;
    logic [1:0]       wb_sel;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, instr, zero, pos, mem_ready,
        output aluin1, aluin2, aluop, pc_write, ir_write, reg_write,
               wb_sel, mem_req, mem_we, iord, halted, fault, retired
    );

    modport slave (
        output run, instr, zero, pos, mem_ready,
        input  aluin1, aluin2, aluop, pc_write, ir_write, reg_write,
               wb_sel, mem_req, mem_we, iord, halted, fault, retired
    );
endinterface

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Counts cycles spent waiting on memory. limit_hit flags the cycle on which
// the wait would reach MEM_TIMEOUT, so the controller can leave that same cycle.
module multicycle_control_fsm_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic limit_hit
);
    localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] LIMIT_M1 = TW'(MEM_TIMEOUT - 1);

    logic [TW-1:0] count_r;

    // Wait counter: cleared on entry to a memory-wait state, advances while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (count_en) begin
            count_r <= count_r + TW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // The current stalled cycle is the MEM_TIMEOUT-th one
    always_comb begin
        limit_hit = count_en && (count_r == LIMIT_M1);
    end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle instruction sequencer for the 16-bit execute datapath: steps each
// instruction through fetch/decode/execute/memory/write-back/branch, waits on a
// variable-latency memory with a timeout, and counts retired instructions.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_control_fsm_if.master bus
);
    state_e           state_r;
    state_e           state_next_s;
    logic             zflag_r;
    logic             pflag_r;
    logic [CNT_W-1:0] retired_r;
    logic             halted_r;
    logic             fault_r;

    logic [3:0]       opcode_s;
    logic             unused_instr_s;
    logic             aluin1_s;
    logic [1:0]       aluin2_s;
    logic             aluop_s;
    logic             pc_write_s;
    logic             ir_write_s;
    logic             reg_write_s;
    logic [1:0]       wb_sel_s;
    logic             mem_req_s;
    logic             mem_we_s;
    logic             iord_s;
    logic             retire_s;
    logic             flag_load_s;
    logic             timeout_s;
    logic             timer_clear_s;
    logic             timer_en_s;
    logic             limit_hit_s;

    assign opcode_s       = bus.instr[15:12];
    assign unused_instr_s = ^bus.instr[11:0];

    multicycle_control_fsm_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear_s),
        .count_en  (timer_en_s),
        .limit_hit (limit_hit_s)
    );

    // Timer restarts whenever a memory-wait state is freshly entered
    always_comb begin
        timer_en_s    = mem_req_s && !bus.mem_ready;
        timer_clear_s = ((state_next_s == ST_FETCH) || (state_next_s == ST_MEM))
                        && (state_next_s != state_r);
    end

    // Next-state and Moore control decode from state and opcode
    always_comb begin
        state_next_s = state_r;
        aluin1_s     = ALUIN1_PC;
        aluin2_s     = ALUIN2_B;
        aluop_s      = ALUOP_ADD;
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        wb_sel_s     = WB_ALU;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        iord_s       = IORD_PC;
        retire_s     = 1'b0;
        flag_load_s  = 1'b0;
        timeout_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.run) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                mem_req_s = 1'b1;
                iord_s    = IORD_PC;
                if (bus.mem_ready) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    aluin1_s     = ALUIN1_PC;
                    aluin2_s     = ALUIN2_TWO;
                    aluop_s      = ALUOP_ADD;
                    state_next_s = ST_DECODE;
                end else if (limit_hit_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (is_legal_op(opcode_s)) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            ST_EXEC: begin
                case (opcode_s)
                    OP_ADD: begin
                        aluin1_s = ALUIN1_A; aluin2_s = ALUIN2_B; aluop_s = ALUOP_ADD;
                        state_next_s = ST_WB;
                    end
                    OP_SUB: begin
                        aluin1_s = ALUIN1_A; aluin2_s = ALUIN2_B; aluop_s = ALUOP_SUB;
                        state_next_s = ST_WB;
                    end
                    OP_ADDI: begin
                        aluin1_s = ALUIN1_A; aluin2_s = ALUIN2_IMM; aluop_s = ALUOP_ADD;
                        state_next_s = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        aluin1_s = ALUIN1_A; aluin2_s = ALUIN2_IMM; aluop_s = ALUOP_ADD;
                        state_next_s = ST_MEM;
                    end
                    OP_BEQ, OP_BGT: begin
                        aluin1_s = ALUIN1_A; aluin2_s = ALUIN2_B; aluop_s = ALUOP_SUB;
                        flag_load_s  = 1'b1;
                        state_next_s = ST_BRANCH;
                    end
                    OP_JAL: begin
                        reg_write_s  = 1'b1;
                        wb_sel_s     = WB_PC;
                        state_next_s = ST_BRANCH;
                    end
                    default: begin
                        state_next_s = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req_s = 1'b1;
                iord_s    = IORD_ALU;
                mem_we_s  = (opcode_s == OP_SW);
                if (bus.mem_ready) begin
                    if (opcode_s == OP_SW) begin
                        retire_s     = 1'b1;
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_WB;
                    end
                end else if (limit_hit_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_WB: begin
                reg_write_s  = 1'b1;
                wb_sel_s     = (opcode_s == OP_LW) ? WB_MEM : WB_ALU;
                retire_s     = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_BRANCH: begin
                aluin1_s = ALUIN1_PC;
                aluin2_s = ALUIN2_IMM;
                aluop_s  = ALUOP_ADD;
                if (opcode_s == OP_BEQ) begin
                    pc_write_s = zflag_r;
                end else if (opcode_s == OP_BGT) begin
                    pc_write_s = pflag_r;
                end else begin
                    pc_write_s = 1'b1;
                end
                retire_s     = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register, branch flags, retire counter and sticky status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            zflag_r   <= 1'b0;
            pflag_r   <= 1'b0;
            retired_r <= '0;
            halted_r  <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (flag_load_s) begin
                zflag_r <= bus.zero;
                pflag_r <= bus.pos;
            end else begin
                zflag_r <= zflag_r;
                pflag_r <= pflag_r;
            end
            if (retire_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end else begin
                retired_r <= retired_r;
            end
            halted_r <= halted_r || (state_next_s == ST_HALT);
            fault_r  <= fault_r || timeout_s;
        end
    end

    assign bus.aluin1    = aluin1_s;
    assign bus.aluin2    = aluin2_s;
    assign bus.aluop     = aluop_s;
    assign bus.pc_write  = pc_write_s;
    assign bus.ir_write  = ir_write_s;
    assign bus.reg_write = reg_write_s;
    assign bus.wb_sel    = wb_sel_s;
    assign bus.mem_req   = mem_req_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.iord      = iord_s;
    assign bus.halted    = halted_r;
    assign bus.fault     = fault_r;
    assign bus.retired   = retired_r;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multicycle controller. A full-width instance covers
// sequencing, memory waits, branches, halts and the 16-cycle timeout; a
// 4-bit-counter, MEM_TIMEOUT=1 instance covers counter wrap and the minimum timeout.
module tb_multicycle_control_fsm;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    multicycle_control_fsm_if #(.CNT_W(16)) bus ();
    multicycle_control_fsm_if #(.CNT_W(4))  bus4 ();

    multicycle_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multicycle_control_fsm #(.MEM_TIMEOUT(1), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs an expected control vector: aluin1,aluin2,aluop,pc_write,ir_write,reg_write,wb_sel,mem_req,mem_we,iord
    function automatic logic [11:0] ctl(input logic a1, input logic [1:0] a2, input logic op,
                                        input logic pcw, input logic irw, input logic rw,
                                        input logic [1:0] wb, input logic mr, input logic mw,
                                        input logic io);
        return {a1, a2, op, pcw, irw, rw, wb, mr, mw, io};
    endfunction

    function automatic logic [11:0] obs_ctl();
        return {bus.aluin1, bus.aluin2, bus.aluop, bus.pc_write, bus.ir_write, bus.reg_write,
                bus.wb_sel, bus.mem_req, bus.mem_we, bus.iord};
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.run = 1'b0;  bus.instr = 16'h0000; bus.zero = 1'b0; bus.pos = 1'b0; bus.mem_ready = 1'b0;
        bus4.run = 1'b0; bus4.instr = 16'h0000; bus4.zero = 1'b0; bus4.pos = 1'b0; bus4.mem_ready = 1'b0;
        tick(); tick();
        #1;
        chk("reset_ctl", 32'(obs_ctl()), 32'h0);
        chk("reset_status", {29'h0, bus.halted, bus.fault, 1'b0}, 32'h0);
        chk("reset_retired", 32'(bus.retired), 32'h0);

        // Leave reset, IDLE waits for run
        rst = 1'b0;
        tick();
        #1;
        chk("idle_ctl", 32'(obs_ctl()), 32'h0);
        bus.run = 1'b1;
        tick();                                  // FETCH, memory not ready
        #1;
        chk("fetch_wait_ctl", 32'(obs_ctl()), 32'(ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0)));

        // Reset mid-FETCH
        rst = 1'b1;
        #1;
        chk("rst_fetch_async", 32'(obs_ctl()), 32'h0);
        tick();
        chk("rst_fetch_edge", 32'(obs_ctl()), 32'h0);
        chk("rst_fetch_retired", 32'(bus.retired), 32'h0);
        rst = 1'b0;

        // ADD, zero-wait memory: FETCH/DECODE/EXEC/WB
        tick();                                  // FETCH
        bus.instr = 16'h0000; bus.mem_ready = 1'b1;
        #1;
        chk("add_fetch_ctl", 32'(obs_ctl()), 32'(ctl(1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0)));
        tick();                                  // DECODE
        chk("add_decode_ctl", 32'(obs_ctl()), 32'h0);
        tick();                                  // EXEC
        chk("add_exec_ctl", 32'(obs_ctl()), 32'(ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0)));
        tick();                                  // WB
        chk("add_wb_ctl", 32'(obs_ctl()), 32'(ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0)));
        chk("add_wb_retired", 32'(bus.retired), 32'h0);
        tick();                                  // FETCH after 4 cycles
        chk("add_retired", 32'(bus.retired), 32'h1);

        // LW with three wait cycles in MEM
        bus.instr = 16'h3000;
        tick();                                  // DECODE
        tick();                                  // EXEC
        chk("lw_exec_ctl", 32'(obs_ctl()), 32'(ctl(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0)));
        bus.mem_ready = 1'b0;
        tick();                                  // MEM 1
        chk("lw_mem1_ctl", 32'(obs_ctl()), 32'(ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1)));
        tick();                                  // MEM 2
        chk("lw_mem2_ctl", 32'(obs_ctl()), 32'(ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1)));
        tick();                                  // MEM 3
        chk("lw_mem3_ctl", 32'(obs_ctl()), 32'(ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1)));
        tick();                                  // MEM 4, memory completes
        bus.mem_ready = 1'b1;
        #1;
        chk("lw_mem4_ctl", 32'(obs_ctl()), 32'(ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1)));
        tick();                                  // WB
        chk("lw_wb_ctl", 32'(obs_ctl()), 32'(ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0)));
        tick();                                  // FETCH after 8 cycles
        chk("lw_retired", 32'(bus.retired), 32'h2);

        // SW retires straight from MEM
        bus.instr = 16'h4000;
        tick(); tick(); tick();                  // DECODE, EXEC, MEM
        chk("sw_mem_ctl", 32'(obs_ctl()), 32'(ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1)));
        tick();                                  // FETCH
        chk("sw_retired", 32'(bus.retired), 32'h3);

        // BEQ: zero high in EXEC, dropped in BRANCH -> taken
        bus.instr = 16'h5000;
        tick(); tick();                          // DECODE, EXEC
        bus.zero = 1'b1; bus.pos = 1'b0;
        #1;
        chk("beq_exec_ctl", 32'(obs_ctl()), 32'(ctl(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0)));
        tick();                                  // BRANCH
        bus.zero = 1'b0;
        #1;
        chk("beq_branch_ctl", 32'(obs_ctl()), 32'(ctl(1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0)));
        tick();
        chk("beq_retired", 32'(bus.retired), 32'h4);

        // BGT: pos low in EXEC, raised in BRANCH -> not taken
        bus.instr = 16'h6000;
        tick(); tick();                          // DECODE, EXEC
        bus.pos = 1'b0; bus.zero = 1'b1;
        tick();                                  // BRANCH
        bus.pos = 1'b1; bus.zero = 1'b0;
        #1;
        chk("bgt_branch_ctl", 32'(obs_ctl()), 32'(ctl(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0)));
        tick();
        chk("bgt_retired", 32'(bus.retired), 32'h5);

        // JAL: link write in EXEC, forced PC load in BRANCH
        bus.instr = 16'h7000; bus.pos = 1'b0;
        tick(); tick();                          // DECODE, EXEC
        chk("jal_exec_ctl", 32'(obs_ctl()), 32'(ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0)));
        tick();                                  // BRANCH
        chk("jal_branch_ctl", 32'(obs_ctl()), 32'(ctl(1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0)));
        tick();
        chk("jal_retired", 32'(bus.retired), 32'h6);

        // SUB
        bus.instr = 16'h1000;
        tick(); tick();                          // DECODE, EXEC
        chk("sub_exec_ctl", 32'(obs_ctl()), 32'(ctl(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0)));
        tick(); tick();                          // WB, FETCH
        chk("sub_retired", 32'(bus.retired), 32'h7);

        // Illegal opcode halts without fault; run stays high and is ignored
        bus.instr = 16'hA000;
        tick(); tick();                          // DECODE, HALT
        chk("illegal_status", {30'h0, bus.halted, bus.fault}, 32'h2);
        chk("illegal_ctl", 32'(obs_ctl()), 32'h0);
        tick(); tick();
        chk("illegal_stays", {30'h0, bus.halted, bus.fault}, 32'h2);
        chk("illegal_retired", 32'(bus.retired), 32'h7);

        // Timeout: memory never ready, HALT after 16 FETCH cycles
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        tick();
        chk("halt_cleared_by_rst", {30'h0, bus.halted, bus.fault}, 32'h0);
        rst = 1'b0;
        tick();                                  // FETCH cycle 1
        repeat (15) tick();                      // FETCH cycle 16
        chk("to_fetch16_status", {30'h0, bus.halted, bus.fault}, 32'h0);
        chk("to_fetch16_req", 32'(bus.mem_req), 32'h1);
        tick();
        chk("to_halt_status", {30'h0, bus.halted, bus.fault}, 32'h3);
        chk("to_halt_ctl", 32'(obs_ctl()), 32'h0);

        // Narrow instance: ready on the first (limit) cycle wins
        bus4.instr = 16'h0000; bus4.mem_ready = 1'b1; bus4.run = 1'b1;
        tick();                                  // FETCH
        tick();                                  // DECODE
        chk("w4_ready_wins", {30'h0, bus4.halted, bus4.fault}, 32'h0);
        tick(); tick(); tick();                  // EXEC, WB, FETCH
        chk("w4_first_retire", 32'(bus4.retired), 32'h1);
        repeat (14) begin
            repeat (4) tick();
        end
        chk("w4_retired_max", 32'(bus4.retired), 32'hF);
        repeat (4) tick();
        chk("w4_retired_wrap", 32'(bus4.retired), 32'h0);

        // Narrow instance: single stalled cycle with MEM_TIMEOUT=1 faults
        bus4.mem_ready = 1'b0;
        #1;
        chk("w4_fetch_req", 32'(bus4.mem_req), 32'h1);
        tick();
        chk("w4_timeout_status", {30'h0, bus4.halted, bus4.fault}, 32'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
